// File: rtl/count_tracker.sv
// count_tracker: watches an up/down cycling counter (0..MAXV) and classifies
// each sampled transition as hold, +1 step, -1 step, wrap or load-jump.
// It also keeps a saturating wrap count and a sticky out-of-range flag.
// All outputs are registered, so a pulse appears in the cycle after the
// sampling edge.
module count_tracker #(
    parameter int MAXV  = 4,
    parameter int WRAPW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [2:0]       y_in,
    output logic             step_up,
    output logic             step_dn,
    output logic             wrap_pulse,
    output logic             jump,
    output logic             dir_out,
    output logic [WRAPW-1:0] wraps,
    output logic             range_err,
    output logic             tracking
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [2:0]       MAX_C     = 3'(MAXV);
    localparam logic [WRAPW-1:0] WRAPS_SAT = {WRAPW{1'b1}};
    localparam logic [WRAPW-1:0] WRAPS_ONE = WRAPW'(1);

    state_t           state_q, state_d;
    logic [2:0]       prev_q, prev_d;
    logic             dir_q, dir_d;
    logic [WRAPW-1:0] wraps_q, wraps_d;
    logic             range_err_q, range_err_d;
    logic             tracking_q, tracking_d;
    logic             step_up_q, step_up_d;
    logic             step_dn_q, step_dn_d;
    logic             wrap_q, wrap_d;
    logic             jump_q, jump_d;

    // Next-state and transition classification; clr overrides everything.
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        dir_d       = dir_q;
        wraps_d     = wraps_q;
        range_err_d = range_err_q;
        step_up_d   = 1'b0;
        step_dn_d   = 1'b0;
        wrap_d      = 1'b0;
        jump_d      = 1'b0;

        if (clr) begin
            state_d     = ST_INIT;
            prev_d      = 3'd0;
            dir_d       = 1'b0;
            wraps_d     = {WRAPW{1'b0}};
            range_err_d = 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (en && (y_in > MAX_C)) begin
                        range_err_d = 1'b1;
                        state_d     = ST_FAULT;
                    end else if (en) begin
                        prev_d  = y_in;
                        state_d = ST_TRACK;
                    end else begin
                        state_d = ST_INIT;
                    end
                end
                ST_TRACK: begin
                    if (en && (y_in > MAX_C)) begin
                        // prev keeps the last legal value
                        range_err_d = 1'b1;
                        state_d     = ST_FAULT;
                    end else if (en) begin
                        prev_d = y_in;
                        if (y_in == prev_q) begin
                            jump_d = 1'b0;
                        end else if ((prev_q < MAX_C) && (y_in == prev_q + 3'd1)) begin
                            step_up_d = 1'b1;
                            dir_d     = 1'b1;
                        end else if ((prev_q > 3'd0) && (y_in == prev_q - 3'd1)) begin
                            step_dn_d = 1'b1;
                            dir_d     = 1'b0;
                        end else if ((prev_q == MAX_C) && (y_in == 3'd0)) begin
                            step_up_d = 1'b1;
                            wrap_d    = 1'b1;
                            dir_d     = 1'b1;
                        end else if ((prev_q == 3'd0) && (y_in == MAX_C)) begin
                            step_dn_d = 1'b1;
                            wrap_d    = 1'b1;
                            dir_d     = 1'b0;
                        end else begin
                            jump_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_TRACK;
                    end
                end
                ST_FAULT: begin
                    // Only clr or reset leaves FAULT; en is ignored here.
                    state_d     = ST_FAULT;
                    range_err_d = 1'b1;
                end
                default: begin
                    state_d = ST_INIT;
                end
            endcase

            // The wrap pulse always fires; only the count saturates.
            if (wrap_d && (wraps_q != WRAPS_SAT)) begin
                wraps_d = wraps_q + WRAPS_ONE;
            end else begin
                wraps_d = wraps_d;
            end
        end

        tracking_d = (state_d == ST_TRACK);
    end

    // State, history and registered outputs; async active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_INIT;
            prev_q      <= 3'd0;
            dir_q       <= 1'b0;
            wraps_q     <= {WRAPW{1'b0}};
            range_err_q <= 1'b0;
            tracking_q  <= 1'b0;
            step_up_q   <= 1'b0;
            step_dn_q   <= 1'b0;
            wrap_q      <= 1'b0;
            jump_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            dir_q       <= dir_d;
            wraps_q     <= wraps_d;
            range_err_q <= range_err_d;
            tracking_q  <= tracking_d;
            step_up_q   <= step_up_d;
            step_dn_q   <= step_dn_d;
            wrap_q      <= wrap_d;
            jump_q      <= jump_d;
        end
    end

    assign step_up    = step_up_q;
    assign step_dn    = step_dn_q;
    assign wrap_pulse = wrap_q;
    assign jump       = jump_q;
    assign dir_out    = dir_q;
    assign wraps      = wraps_q;
    assign range_err  = range_err_q;
    assign tracking   = tracking_q;

endmodule

// File: tb/tb_count_tracker.sv
// Bench for count_tracker: table-driven directed vectors, hand sequences for
// saturation / async reset, and randomized traffic checked against a
// modular-arithmetic reference model. A second instance with WRAPW=2
// shares the inputs so that saturation is reachable.
module tb_count_tracker;
    localparam int MAXV = 4;

    logic       clk = 1'b0;
    logic       reset, clr, en;
    logic [2:0] y_in;

    logic       up_a, dn_a, wr_a, jp_a, dir_a, rerr_a, trk_a;
    logic [7:0] wraps_a;
    logic       up_b, dn_b, wr_b, jp_b, dir_b, rerr_b, trk_b;
    logic [1:0] wraps_b;

    count_tracker #(.MAXV(MAXV), .WRAPW(8)) dut_a (
        .clk(clk), .reset(reset), .clr(clr), .en(en), .y_in(y_in),
        .step_up(up_a), .step_dn(dn_a), .wrap_pulse(wr_a), .jump(jp_a),
        .dir_out(dir_a), .wraps(wraps_a), .range_err(rerr_a), .tracking(trk_a)
    );

    count_tracker #(.MAXV(MAXV), .WRAPW(2)) dut_b (
        .clk(clk), .reset(reset), .clr(clr), .en(en), .y_in(y_in),
        .step_up(up_b), .step_dn(dn_b), .wrap_pulse(wr_b), .jump(jp_b),
        .dir_out(dir_b), .wraps(wraps_b), .range_err(rerr_b), .tracking(trk_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: started/faulted flags, last value, and plain counts.
    bit m_started, m_fault;
    int m_prev, m_dir, m_rerr, m_w8, m_w2;
    bit e_up, e_dn, e_wr, e_jp;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_fault = 0; m_prev = 0; m_dir = 0; m_rerr = 0;
        m_w8 = 0; m_w2 = 0; e_up = 0; e_dn = 0; e_wr = 0; e_jp = 0;
    endtask

    task automatic model_step(input bit c, input bit e, input int y);
        int modv;
        modv = MAXV + 1;
        e_up = 0; e_dn = 0; e_wr = 0; e_jp = 0;
        if (c) begin
            m_started = 0; m_fault = 0; m_prev = 0; m_dir = 0; m_rerr = 0;
            m_w8 = 0; m_w2 = 0;
        end else if (m_fault) begin
            m_rerr = 1;
        end else if (e) begin
            if (y > MAXV) begin
                m_rerr = 1; m_fault = 1;
            end else if (!m_started) begin
                m_started = 1; m_prev = y;
            end else begin
                if (y == m_prev) begin
                end else if (y == (m_prev + 1) % modv) begin
                    e_up = 1; m_dir = 1; e_wr = (y == 0);
                end else if (y == (m_prev + modv - 1) % modv) begin
                    e_dn = 1; m_dir = 0; e_wr = (m_prev == 0);
                end else begin
                    e_jp = 1;
                end
                m_prev = y;
                if (e_wr) begin
                    m_w8 = (m_w8 < 255) ? m_w8 + 1 : 255;
                    m_w2 = (m_w2 < 3) ? m_w2 + 1 : 3;
                end
            end
        end
    endtask

    task automatic check_model();
        int trk;
        trk = (m_started && !m_fault) ? 1 : 0;
        chk("step_up", up_a, e_up);
        chk("step_dn", dn_a, e_dn);
        chk("wrap_pulse", wr_a, e_wr);
        chk("jump", jp_a, e_jp);
        chk("dir_out", dir_a, m_dir);
        chk("wraps", wraps_a, m_w8);
        chk("range_err", rerr_a, m_rerr);
        chk("tracking", trk_a, trk);
        chk("b_wrap_pulse", wr_b, e_wr);
        chk("b_wraps", wraps_b, m_w2);
    endtask

    // One sampled cycle: drive at negedge, model at posedge, check #1 later.
    task automatic cyc(input bit c, input bit e, input int y);
        @(negedge clk);
        clr = c; en = e; y_in = 3'(y);
        @(posedge clk);
        model_step(c, e, y);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; clr = 1'b0; en = 1'b0; y_in = 3'd0;
        model_reset();
        #1;
        check_model();
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        bit c; bit e; int y;
        bit up; bit dn; bit wr; bit jp; bit dir; int wraps; bit rerr; bit trk;
    } vec_t;

    vec_t tbl[19];

    initial begin
        reset = 1'b0; clr = 1'b0; en = 1'b0; y_in = 3'd0;

        //          c e y   up dn wr jp dir wraps rerr trk
        tbl[0]  = '{0,1,0,  0, 0, 0, 0, 0,  0,    0,   1};
        tbl[1]  = '{0,1,1,  1, 0, 0, 0, 1,  0,    0,   1};
        tbl[2]  = '{0,1,2,  1, 0, 0, 0, 1,  0,    0,   1};
        tbl[3]  = '{0,1,3,  1, 0, 0, 0, 1,  0,    0,   1};
        tbl[4]  = '{0,1,4,  1, 0, 0, 0, 1,  0,    0,   1};
        tbl[5]  = '{0,1,0,  1, 0, 1, 0, 1,  1,    0,   1};
        tbl[6]  = '{0,1,4,  0, 1, 1, 0, 0,  2,    0,   1};
        tbl[7]  = '{0,1,3,  0, 1, 0, 0, 0,  2,    0,   1};
        tbl[8]  = '{0,1,2,  0, 1, 0, 0, 0,  2,    0,   1};
        tbl[9]  = '{0,1,1,  0, 1, 0, 0, 0,  2,    0,   1};
        tbl[10] = '{0,1,3,  0, 0, 0, 1, 0,  2,    0,   1};
        tbl[11] = '{0,1,4,  1, 0, 0, 0, 1,  2,    0,   1};
        tbl[12] = '{0,0,0,  0, 0, 0, 0, 1,  2,    0,   1};
        tbl[13] = '{0,1,4,  0, 0, 0, 0, 1,  2,    0,   1};
        tbl[14] = '{0,1,6,  0, 0, 0, 0, 1,  2,    1,   0};
        tbl[15] = '{0,1,0,  0, 0, 0, 0, 1,  2,    1,   0};
        tbl[16] = '{1,1,2,  0, 0, 0, 0, 0,  0,    0,   0};
        tbl[17] = '{0,1,2,  0, 0, 0, 0, 0,  0,    0,   1};
        tbl[18] = '{1,1,3,  0, 0, 0, 0, 0,  0,    0,   0};

        #12;
        do_reset();

        // Directed table
        for (int i = 0; i < 19; i++) begin
            cyc(tbl[i].c, tbl[i].e, tbl[i].y);
            chk($sformatf("tbl%0d_up", i), up_a, tbl[i].up);
            chk($sformatf("tbl%0d_dn", i), dn_a, tbl[i].dn);
            chk($sformatf("tbl%0d_wrap", i), wr_a, tbl[i].wr);
            chk($sformatf("tbl%0d_jump", i), jp_a, tbl[i].jp);
            chk($sformatf("tbl%0d_dir", i), dir_a, tbl[i].dir);
            chk($sformatf("tbl%0d_wraps", i), wraps_a, tbl[i].wraps);
            chk($sformatf("tbl%0d_rerr", i), rerr_a, tbl[i].rerr);
            chk($sformatf("tbl%0d_trk", i), trk_a, tbl[i].trk);
        end

        // Out-of-range as the very first sample goes straight to FAULT
        do_reset();
        cyc(0, 1, 7);
        chk("init_oor_rerr", rerr_a, 1);
        chk("init_oor_trk", trk_a, 0);
        cyc(0, 1, 1);
        chk("init_oor_stays", trk_a, 0);

        // Saturation on the 2-bit wrap counter: five up-wraps
        do_reset();
        cyc(0, 1, 0);
        for (int k = 0; k < 5; k++) begin
            for (int v = 1; v <= 4; v++) cyc(0, 1, v);
            cyc(0, 1, 0);
            chk($sformatf("sat%0d_pulse", k), wr_b, 1);
            chk($sformatf("sat%0d_wraps", k), wraps_b, (k < 3) ? k + 1 : 3);
        end

        // Async reset mid-stream, between clock edges
        cyc(0, 1, 4);
        cyc(0, 1, 0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_up", up_a, 0);
        chk("async_wrap", wr_a, 0);
        chk("async_dir", dir_a, 0);
        chk("async_wraps", wraps_a, 0);
        chk("async_trk", trk_a, 0);
        chk("async_b_wraps", wraps_b, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bit c, e;
            int r, y;
            c = ($urandom_range(0, 39) == 0);
            e = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r < 4)      y = (m_prev + 1) % (MAXV + 1);
            else if (r < 7) y = (m_prev + MAXV) % (MAXV + 1);
            else if (r < 8) y = m_prev;
            else if (r < 9) y = $urandom_range(0, 7);
            else            y = $urandom_range(0, MAXV);
            cyc(c, e, y);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
